// File: rtl/fcc_frame_streamer.sv
// Range-image frame source: holds one ROWS x COLS point frame loaded over a config
// port and replays it raster-order over a valid/ready stream, optionally skipping ground.
module fcc_frame_streamer #(
  parameter int W      = 16,
  parameter int ROWS   = 30,
  parameter int COLS   = 30,
  parameter int ROW_W  = 8,
  parameter int COL_W  = 5,
  parameter int ADDR_W = 10,
  parameter int FRM_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [W-1:0]        cfg_x,
  input  logic [W-1:0]        cfg_y,
  input  logic [W-1:0]        cfg_z,
  input  logic                cfg_ground,
  input  logic                start,
  input  logic                stop,
  input  logic [FRM_W-1:0]    num_frames,
  input  logic                skip_ground,
  output logic                busy,
  output logic                done,
  output logic                frame_end,
  output logic [FRM_W-1:0]    frame_cnt,
  output logic [31:0]         point_cnt,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [ROW_W-1:0]    m_row,
  output logic [COL_W-1:0]    m_col,
  output logic [W-1:0]        m_x,
  output logic [W-1:0]        m_y,
  output logic [W-1:0]        m_z,
  output logic                m_is_ground,
  output logic                m_sof
);

  localparam logic [ADDR_W:0] NPTS = (ADDR_W+1)'(ROWS*COLS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_d;

  logic [3*W:0]      mem [ROWS*COLS];
  logic [3*W:0]      q;
  logic [ROW_W-1:0]  row, rd_row;
  logic [COL_W-1:0]  col, rd_col;
  logic [ADDR_W-1:0] addr;
  logic [FRM_W-1:0]  num_q, ffr;
  logic rd_vld, rd_last, fetching, skip_q, sof_pend, m_last;
  logic fe, take_out, skip_rd, start_run, finish, xfer, out_free, last_pos;

  assign xfer      = m_valid && m_ready;
  assign out_free  = !m_valid || m_ready;
  assign last_pos  = (row == ROW_W'(ROWS-1)) && (col == COL_W'(COLS-1));
  assign busy      = (state != IDLE);
  assign frame_end = (xfer && m_last) || (skip_rd && rd_last);

  // Point memory is deliberately outside the reset domain so frames survive rst.
  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE && ({1'b0, cfg_addr} < NPTS))
      mem[cfg_addr] <= {cfg_x, cfg_y, cfg_z, cfg_ground};
    if (fe)
      q <= mem[addr];
  end

  always_comb begin
    state_d   = state;
    fe        = 1'b0;
    take_out  = 1'b0;
    skip_rd   = 1'b0;
    start_run = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_d   = RUN;
        start_run = 1'b1;
      end
      RUN: if (stop) begin
        if (m_valid && !m_ready) state_d = DRAIN;
        else begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end else begin
        skip_rd  = rd_vld && skip_q && q[0];
        take_out = rd_vld && !skip_rd && out_free;
        fe       = fetching && (!rd_vld || skip_rd || take_out);
        // Fetch has stopped after the final frame; end once the pipe empties.
        if (!fetching && (!rd_vld || skip_rd) && out_free) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      DRAIN: if (m_ready) begin
        state_d = IDLE;
        finish  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done <= 1'b0; frame_cnt <= '0; point_cnt <= '0;
      row <= '0; col <= '0; addr <= '0; ffr <= '0; num_q <= '0;
      rd_vld <= 1'b0; rd_last <= 1'b0; rd_row <= '0; rd_col <= '0;
      fetching <= 1'b0; skip_q <= 1'b0; sof_pend <= 1'b0; m_last <= 1'b0;
      m_valid <= 1'b0; m_row <= '0; m_col <= '0;
      m_x <= '0; m_y <= '0; m_z <= '0; m_is_ground <= 1'b0; m_sof <= 1'b0;
    end else begin
      state <= state_d;
      done  <= finish;
      if (start_run) begin
        frame_cnt <= '0; point_cnt <= '0;
        row <= '0; col <= '0; addr <= '0; ffr <= '0;
        num_q <= num_frames; skip_q <= skip_ground;
        fetching <= 1'b1; sof_pend <= 1'b1;
        rd_vld <= 1'b0; m_valid <= 1'b0;
      end else begin
        if (xfer) point_cnt <= point_cnt + 32'd1;
        if (frame_end && frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;

        if (fe) begin
          rd_vld  <= 1'b1;
          rd_row  <= row;
          rd_col  <= col;
          rd_last <= last_pos;
          if (col == COL_W'(COLS-1)) begin
            col <= '0;
            if (row == ROW_W'(ROWS-1)) begin
              row  <= '0;
              addr <= '0;
              ffr  <= ffr + 1'b1;
              if (num_q != '0 && ffr == num_q - 1'b1) fetching <= 1'b0;
            end else begin
              row  <= row + 1'b1;
              addr <= addr + 1'b1;
            end
          end else begin
            col  <= col + 1'b1;
            addr <= addr + 1'b1;
          end
        end else if (skip_rd || take_out) begin
          rd_vld <= 1'b0;
        end

        if (take_out) begin
          m_valid  <= 1'b1;
          m_row    <= rd_row;
          m_col    <= rd_col;
          {m_x, m_y, m_z, m_is_ground} <= q;
          m_sof    <= sof_pend;
          m_last   <= rd_last;
          sof_pend <= rd_last;
        end else begin
          if (xfer) m_valid <= 1'b0;
          if (skip_rd && rd_last) sof_pend <= 1'b1;
        end

        // Early stop discards any prefetched entry; a held beat drains in DRAIN.
        if (state == RUN && stop) begin
          fetching <= 1'b0;
          rd_vld   <= 1'b0;
        end
      end
    end
  end

endmodule
